ppu_pixel_mixer: RTL

- Per-scanline compositor; sits directly upstream of the row RAM that feeds HDMI video output.
- On `start`, walks one row of pixels and reads three source line buffers in lockstep: background tile engine, foreground tile engine, sprite engine.
- Resolves layer priority and transparency per pixel, then writes the winning 10-bit pixel word into the row RAM write port.
- Pulses `done` when the row has been fully written.

---
 rtl/ppu_pkg.sv | 26 ++
 rtl/ppu_mix_prio.sv | 37 +++
 rtl/ppu_pixel_mixer.sv | 110 +++++++++++
 3 files changed

// File: rtl/ppu_pkg.sv
// Shared constants and pixel types for the PPU scanline compositor.
package ppu_pkg;

  localparam int unsigned ROW_W   = 320;
  localparam int unsigned ADDR_W  = 9;
  localparam int unsigned PIX_W   = 10;
  localparam int unsigned COLOR_W = 4;
  localparam int unsigned PAL_W   = PIX_W - COLOR_W;

  typedef struct packed {
    logic [PAL_W-1:0]   palette;
    logic [COLOR_W-1:0] color;
  } pixel_t;

  typedef struct packed {
    logic [1:0] prio;
    pixel_t     pix;
  } spr_pixel_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN
  } mixer_state_t;

endpackage

// File: rtl/ppu_mix_prio.sv
// Per-pixel layer resolve: picks the highest-priority opaque layer, else backdrop.
module ppu_mix_prio
  import ppu_pkg::*;
(
  input  pixel_t     bg,
  input  pixel_t     fg,
  input  spr_pixel_t spr,
  input  logic       bg_en,
  input  logic       fg_en,
  input  logic       spr_en,
  output pixel_t     mix
);

  logic bg_op;
  logic fg_op;
  logic spr_op;

  assign bg_op  = bg_en && (bg.color != '0);
  assign fg_op  = fg_en && (fg.color != '0);
  assign spr_op = spr_en && (spr.pix.color != '0) && (spr.prio != 2'd0);

  always_comb begin
    mix = '0;
    if (spr_op && (spr.prio == 2'd3)) begin
      mix = spr.pix;
    end else if (fg_op) begin
      mix = fg;
    end else if (spr_op && (spr.prio == 2'd2)) begin
      mix = spr.pix;
    end else if (bg_op) begin
      mix = bg;
    end else if (spr_op) begin
      mix = spr.pix;
    end
  end

endmodule

// File: rtl/ppu_pixel_mixer.sv
// Scanline compositor: reads bg/fg/sprite line buffers and writes the mixed row to row RAM.
module ppu_pixel_mixer #(
  parameter int unsigned ROW_W  = ppu_pkg::ROW_W,
  parameter int unsigned ADDR_W = ppu_pkg::ADDR_W,
  parameter int unsigned PIX_W  = ppu_pkg::PIX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              bg_en,
  input  logic              fg_en,
  input  logic              spr_en,
  output logic [ADDR_W-1:0] src_rdaddr,
  input  logic [PIX_W-1:0]  bg_rddata,
  input  logic [PIX_W-1:0]  fg_rddata,
  input  logic [PIX_W+1:0]  spr_rddata,
  output logic [ADDR_W-1:0] rowram_wraddr,
  output logic [PIX_W-1:0]  rowram_wrdata,
  output logic              rowram_wren,
  output logic              busy,
  output logic              done
);
  import ppu_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROW_W - 1);

  mixer_state_t      state;
  mixer_state_t      state_next;
  logic [ADDR_W-1:0] counter;
  logic              drain_cnt;
  logic              bg_en_q;
  logic              fg_en_q;
  logic              spr_en_q;
  logic              s1_valid;
  logic [ADDR_W-1:0] s1_addr;
  logic              accept;
  pixel_t            mix_pix;

  assign accept     = (state == ST_IDLE) && start;
  assign busy       = (state != ST_IDLE);
  assign src_rdaddr = (state == ST_READ) ? counter : '0;

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_READ;
      ST_READ:  if (counter == LAST_ADDR) state_next = ST_DRAIN;
      ST_DRAIN: if (drain_cnt) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  ppu_mix_prio u_mix (
    .bg     (bg_rddata),
    .fg     (fg_rddata),
    .spr    (spr_rddata),
    .bg_en  (bg_en_q),
    .fg_en  (fg_en_q),
    .spr_en (spr_en_q),
    .mix    (mix_pix)
  );

  // S1 tracks the address whose data lands on the line buffer outputs next cycle;
  // S2 registers the mixed result together with that address.
  always_ff @(posedge clk) begin
    if (rst) begin
      counter       <= '0;
      drain_cnt     <= 1'b0;
      bg_en_q       <= 1'b0;
      fg_en_q       <= 1'b0;
      spr_en_q      <= 1'b0;
      s1_valid      <= 1'b0;
      s1_addr       <= '0;
      rowram_wren   <= 1'b0;
      rowram_wraddr <= '0;
      rowram_wrdata <= '0;
      done          <= 1'b0;
    end else begin
      if (accept) begin
        counter  <= '0;
        bg_en_q  <= bg_en;
        fg_en_q  <= fg_en;
        spr_en_q <= spr_en;
      end else if ((state == ST_READ) && (counter != LAST_ADDR)) begin
        counter <= counter + ADDR_W'(1);
      end

      drain_cnt <= (state == ST_DRAIN) ? ~drain_cnt : 1'b0;

      s1_valid <= (state == ST_READ);
      s1_addr  <= counter;

      rowram_wren   <= s1_valid;
      rowram_wraddr <= s1_addr;
      if (s1_valid) begin
        rowram_wrdata <= mix_pix;
      end
      done <= s1_valid && (s1_addr == LAST_ADDR);
    end
  end

endmodule
